// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the data port and the unified-memory bus of mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned INST_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [INST_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data load/store;
// data wins contention, a starvation counter forces fetch through after STARVE_MAX losses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned INST_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              sel_hi_q, sel_hi_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [INST_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              grant_if_c;
  logic              done_c;
  logic              unused_addr_lsb;

  // Fetch addresses are word-granular; the low byte-offset bits carry no information.
  assign unused_addr_lsb = ^bus.if_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      starve_q    <= '0;
      sel_hi_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      sel_hi_q    <= sel_hi_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    sel_hi_d    = sel_hi_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    grant_if_c  = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant_if_c = bus.if_req && (!bus.d_req || (starve_q == STV_MAX));
          state_d    = ISSUE;
          mem_en_d   = 1'b1;
          if (grant_if_c) begin
            owner_d     = OWN_IF;
            mem_addr_d  = {bus.if_addr[ADDR_W-1:3], 3'b000};
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
            sel_hi_d    = bus.if_addr[2];
            starve_d    = '0;
          end else begin
            owner_d     = OWN_D;
            mem_addr_d  = bus.d_addr;
            mem_we_d    = bus.d_we;
            mem_wdata_d = bus.d_wdata;
            sel_hi_d    = 1'b0;
            // Only a loss with fetch actually waiting counts toward starvation.
            if (bus.if_req && (starve_q != STV_MAX)) starve_d = starve_q + STV_W'(1);
          end
        end
      end
      ISSUE: begin
        if (mem_we_q || (LAT_INIT == '0)) begin
          done_c  = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d   = LAT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          done_c  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Capture the memory word on the edge that enters RESP, steered to the owning port.
    if (done_c) begin
      if (owner_q == OWN_IF) begin
        if_ready_d = 1'b1;
        if_rdata_d = sel_hi_q ? bus.mem_rdata[2*INST_W-1:INST_W] : bus.mem_rdata[INST_W-1:0];
      end else begin
        d_ready_d = 1'b1;
        d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;

endmodule
